ex_forward_stage: RTL
=====================

EX_FORWARD_STAGE -- requirements
Module: ex_forward_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall_e  input  1  holds the ID/EX register when high.
REQ-004 SHALL have ports valid_d, reg_write_d, branch_d, jump_d  input  1 each  decode-stage control.
REQ-005 SHALL have port result_src_d  input  3  decode-stage result select.
REQ-006 SHALL have ports rs1_d, rs2_d, rd_d  input  5 each  decode-stage register indices.
REQ-007 SHALL have ports rd1_d, rd2_d, imm_d, pc_d  input  32 each  decode-stage operands, immediate and PC.
REQ-008 SHALL have ports forward_ae, forward_be  input  2 each  operand selects: 00 register file, 10 memory stage, 01 writeback stage, 11 buffer stage.
REQ-009 SHALL have port flush  input  1  kills the instruction entering execute.
REQ-010 SHALL have ports alu_result_m, result_w  input  32 each  memory and writeback results.
REQ-011 SHALL have ports rd_w  input  5 and reg_write_w  input  1  writeback destination.
REQ-012 SHALL have ports valid_e, reg_write_e, branch_e, jump_e  output  1 each; result_src_e  output  3; rs1_e, rs2_e, rd_e  output  5 each; pc_e, imm_e  output  32 each  registered ID/EX contents.
REQ-013 SHALL have ports src_a_e, write_data_e  output  32 each  forwarded rs1 and rs2 operands.
REQ-014 SHALL have ports rd_b  output  5, reg_write_b  output  1, result_b  output  32  buffer-stage destination and data.
REQ-015 SHALL have port flush_count  output  32  flush event counter (present only with FLUSH_CNT_EN).

Function
REQ-016 ID/EX register SHALL, per rising edge, in priority: flush -> load bubble; else stall_e -> hold; else load all *_d values into *_e.
REQ-017 A bubble SHALL be valid_e, reg_write_e, branch_e, jump_e = 0, rs1_e, rs2_e, rd_e = 0, result_src_e = 0, rd1/rd2/imm/pc registers = 0.
REQ-018 flush and stall_e asserted together SHALL produce a bubble (flush wins).
REQ-019 src_a_e SHALL be combinational from the registered rd1 value: 00 registered rd1, 10 alu_result_m, 01 result_w, 11 result_b.
REQ-020 write_data_e SHALL use the same mapping with forward_be and the registered rd2 value.
REQ-021 Forward muxes SHALL add zero cycles of latency; ID/EX outputs SHALL have one cycle of latency from the *_d inputs.
REQ-022 Buffer stage SHALL capture rd_w, reg_write_w and result_w every rising edge, independent of flush and stall_e.
REQ-023 reg_write_b SHALL be captured as 0 when rd_w = 0, regardless of reg_write_w.
REQ-024 Buffer stage SHALL hold exactly the previous cycle's writeback values, one cycle deep, with no enable.

Reset
REQ-025 While rst is high, all ID/EX outputs SHALL equal the bubble values, rd_b = 0, reg_write_b = 0, result_b = 0 and flush_count = 0, immediately and without waiting for a clock edge.
REQ-026 rst asserted mid-stall or mid-flush SHALL override both; the first edge after release SHALL follow REQ-016.

Configuration
REQ-027 Macro FLUSH_CNT_EN defined: flush_count SHALL increment by 1 on each rising edge with flush high, and SHALL saturate at 0xFFFFFFFF.
REQ-028 Macro FLUSH_CNT_EN undefined: the flush_count port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Bench SHALL load rd1_d = 0x11, rd2_d = 0x22 with forward selects 00 -> next cycle src_a_e = 0x11 and write_data_e = 0x22.
REQ-030 Bench SHALL set alu_result_m = 0xA, result_w = 0xB, result_b = 0xC and sweep forward_ae through 10, 01, 11 -> src_a_e = 0xA, 0xB, 0xC in the same cycle.
REQ-031 Bench SHALL assert flush and stall_e together with reg_write_d = 1 and rd_d = 5 -> next cycle reg_write_e = 0, rd_e = 0, valid_e = 0.
REQ-032 Bench SHALL hold stall_e for 3 cycles while the *_d inputs change -> *_e outputs stay constant and the buffer stage keeps updating.
REQ-033 Bench SHALL drive rd_w = 0 with reg_write_w = 1 and result_w = 0xFF -> next cycle reg_write_b = 0 and result_b = 0xFF.
REQ-034 With FLUSH_CNT_EN, bench SHALL pulse flush 4 times, assert rst asynchronously, then pulse flush once more -> flush_count reads 4, then 0 during reset, then 1.

Source files
------------

// File: rtl/ex_forward_stage_if.sv
// Bus between the decode side and the execute/forwarding stage.
// The flush_count signal exists only when FLUSH_CNT_EN is defined.
interface ex_forward_stage_if;
  // Decode-stage inputs and pipeline control
  logic        stall_e;
  logic        flush;
  logic        valid_d;
  logic        reg_write_d;
  logic        branch_d;
  logic        jump_d;
  logic [2:0]  result_src_d;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] imm_d;
  logic [31:0] pc_d;

  // Forwarding selects and the later-stage results they pick from
  logic [1:0]  forward_ae;
  logic [1:0]  forward_be;
  logic [31:0] alu_result_m;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;

  // ID/EX register contents
  logic        valid_e;
  logic        reg_write_e;
  logic        branch_e;
  logic        jump_e;
  logic [2:0]  result_src_e;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_e;
  logic [31:0] imm_e;

  // Forwarded operands and the buffer stage
  logic [31:0] src_a_e;
  logic [31:0] write_data_e;
  logic [4:0]  rd_b;
  logic        reg_write_b;
  logic [31:0] result_b;
`ifdef FLUSH_CNT_EN
  logic [31:0] flush_count;
`endif

  modport master (
    output stall_e, flush, valid_d, reg_write_d, branch_d, jump_d,
    output result_src_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, pc_d,
    output forward_ae, forward_be, alu_result_m, result_w, rd_w, reg_write_w,
`ifdef FLUSH_CNT_EN
    input  flush_count,
`endif
    input  valid_e, reg_write_e, branch_e, jump_e, result_src_e,
    input  rs1_e, rs2_e, rd_e, pc_e, imm_e,
    input  src_a_e, write_data_e, rd_b, reg_write_b, result_b
  );

  modport slave (
    input  stall_e, flush, valid_d, reg_write_d, branch_d, jump_d,
    input  result_src_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, pc_d,
    input  forward_ae, forward_be, alu_result_m, result_w, rd_w, reg_write_w,
`ifdef FLUSH_CNT_EN
    output flush_count,
`endif
    output valid_e, reg_write_e, branch_e, jump_e, result_src_e,
    output rs1_e, rs2_e, rd_e, pc_e, imm_e,
    output src_a_e, write_data_e, rd_b, reg_write_b, result_b
  );
endinterface

// File: rtl/ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding and a one-deep writeback buffer.
// Optional saturating flush counter enabled by defining FLUSH_CNT_EN.
module ex_forward_stage (
  input  logic              clk,
  input  logic              rst,
  ex_forward_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic [2:0]  result_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } idex_t;

  idex_t       r_idex;
  idex_t       w_idex_d;
  logic [4:0]  r_rd_b;
  logic        r_reg_write_b;
  logic [31:0] r_result_b;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;

  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_val,
    input logic [31:0] mem_val,
    input logic [31:0] wb_val,
    input logic [31:0] buf_val
  );
    logic [31:0] res;
    case (sel)
      2'b10:   res = mem_val;
      2'b01:   res = wb_val;
      2'b11:   res = buf_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

  always_comb begin
    w_idex_d            = '0;
    w_idex_d.valid      = bus.valid_d;
    w_idex_d.reg_write  = bus.reg_write_d;
    w_idex_d.branch     = bus.branch_d;
    w_idex_d.jump       = bus.jump_d;
    w_idex_d.result_src = bus.result_src_d;
    w_idex_d.rs1        = bus.rs1_d;
    w_idex_d.rs2        = bus.rs2_d;
    w_idex_d.rd         = bus.rd_d;
    w_idex_d.rd1        = bus.rd1_d;
    w_idex_d.rd2        = bus.rd2_d;
    w_idex_d.imm        = bus.imm_d;
    w_idex_d.pc         = bus.pc_d;
  end

  // Flush outranks stall: a killed instruction must never be held in execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= '0;
    end else if (bus.flush) begin
      r_idex <= '0;
    end else if (!bus.stall_e) begin
      r_idex <= w_idex_d;
    end
  end

  // Buffer stage runs every cycle so a stalled consumer still sees last writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_b        <= '0;
      r_reg_write_b <= 1'b0;
      r_result_b    <= '0;
    end else begin
      r_rd_b        <= bus.rd_w;
      r_reg_write_b <= bus.reg_write_w && (bus.rd_w != 5'd0);
      r_result_b    <= bus.result_w;
    end
  end

  always_comb begin
    w_src_a = fwd_mux(bus.forward_ae, r_idex.rd1, bus.alu_result_m, bus.result_w, r_result_b);
    w_src_b = fwd_mux(bus.forward_be, r_idex.rd2, bus.alu_result_m, bus.result_w, r_result_b);
  end

`ifdef FLUSH_CNT_EN
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_count <= '0;
    end else if (bus.flush && (r_flush_count != 32'hFFFF_FFFF)) begin
      r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign bus.flush_count = r_flush_count;
`endif

  assign bus.valid_e      = r_idex.valid;
  assign bus.reg_write_e  = r_idex.reg_write;
  assign bus.branch_e     = r_idex.branch;
  assign bus.jump_e       = r_idex.jump;
  assign bus.result_src_e = r_idex.result_src;
  assign bus.rs1_e        = r_idex.rs1;
  assign bus.rs2_e        = r_idex.rs2;
  assign bus.rd_e         = r_idex.rd;
  assign bus.pc_e         = r_idex.pc;
  assign bus.imm_e        = r_idex.imm;
  assign bus.src_a_e      = w_src_a;
  assign bus.write_data_e = w_src_b;
  assign bus.rd_b         = r_rd_b;
  assign bus.reg_write_b  = r_reg_write_b;
  assign bus.result_b     = r_result_b;

endmodule
